// File: rtl/riscv_pkg.sv
// Shared RV32I issue-stage types: ALU operation codes, opcode constants and
// the packet presented to the ALU.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    // Packet layout is fixed by XLEN/REG_W; the stage parameters must match them.
    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        alu_op_e          alu_ctrl;
        logic [REG_W-1:0] rd;
        logic             illegal;
    } issue_pkt_t;

    // funct3 to ALU op; alt selects SUB (funct3 000) or SRA (funct3 101).
    function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU control and
// operand selects for the issue stage.
module alu_op_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_e    alu_ctrl,
    output logic       b_is_imm,
    output logic       a_zero,
    output logic       illegal
);

    // Resolve operation and operand routing per opcode class
    always_comb begin
        alu_ctrl = AluAdd;
        b_is_imm = 1'b0;
        a_zero   = 1'b0;
        illegal  = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                alu_ctrl = funct3_to_op(funct3, funct7_5);
            end
            OPC_OP_IMM: begin
                // Bit 30 is part of the immediate except for shifts-right.
                alu_ctrl = funct3_to_op(funct3, funct7_5 && (funct3 == 3'b101));
                b_is_imm = 1'b1;
            end
            OPC_LUI: begin
                alu_ctrl = AluPassB;
                b_is_imm = 1'b1;
                a_zero   = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I integer ops, selects operands and presents a
// registered packet to the ALU behind valid/ready with a 2-entry skid buffer.
// Optional macro ALU_ISSUE_FWD_EN enables ALU writeback forwarding at capture.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned REG_ADDR_W = REG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic [3:0]            alu_ctrl,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  illegal
);

    alu_op_e                dec_ctrl;
    logic                   dec_b_imm;
    logic                   dec_a_zero;
    logic                   dec_illegal;
    logic [DATA_WIDTH-1:0]  rs1_val;
    logic [DATA_WIDTH-1:0]  rs2_val;
    issue_pkt_t             new_pkt;

    logic                   out_valid_q, out_valid_d;
    issue_pkt_t             out_pkt_q, out_pkt_d;
    logic                   skid_valid_q, skid_valid_d;
    issue_pkt_t             skid_pkt_q, skid_pkt_d;
    logic                   accept;
    logic                   drain;

    alu_op_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (dec_ctrl),
        .b_is_imm (dec_b_imm),
        .a_zero   (dec_a_zero),
        .illegal  (dec_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    // Forward the in-flight ALU result over stale register-file data (x0 never forwards)
    always_comb begin
        rs1_val = rs1_data;
        rs2_val = rs2_data;
        if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs1_addr)) rs1_val = fwd_data;
        if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs2_addr)) rs2_val = fwd_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs1_addr, rs2_addr};
    assign rs1_val    = rs1_data;
    assign rs2_val    = rs2_data;
`endif

    // Build the packet captured on accept
    always_comb begin
        new_pkt          = '0;
        new_pkt.a        = dec_a_zero ? '0 : rs1_val;
        new_pkt.b        = dec_b_imm ? imm : rs2_val;
        new_pkt.alu_ctrl = dec_ctrl;
        new_pkt.rd       = rd_in;
        new_pkt.illegal  = dec_illegal;
    end

    // in_ready depends only on skid occupancy, never on out_ready
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = out_valid_q && out_ready;

    // Next-state for output register and skid entry
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pkt_d    = out_pkt_q;
        skid_valid_d = skid_valid_q;
        skid_pkt_d   = skid_pkt_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            // Skid full implies no accept this cycle (in_ready low).
            if (skid_valid_q) begin
                out_pkt_d    = skid_pkt_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_pkt_d = new_pkt;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_pkt_d   = new_pkt;
            end else begin
                skid_valid_d = 1'b1;
                skid_pkt_d   = new_pkt;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_pkt_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pkt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pkt_q    <= out_pkt_d;
            skid_valid_q <= skid_valid_d;
            skid_pkt_q   <= skid_pkt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = out_pkt_q.a;
    assign b         = out_pkt_q.b;
    assign alu_ctrl  = out_pkt_q.alu_ctrl;
    assign rd_out    = out_pkt_q.rd;
    assign illegal   = out_pkt_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized
// traffic against a queue-based reference model.
module tb_alu_issue_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rs1_addr, rs2_addr, rd_in, fwd_rd, rd_out;
    logic [31:0] rs1_data, rs2_data, imm, fwd_data, a, b;
    logic        fwd_valid;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;
    issue_pkt_t exp_q[$];

    localparam alu_op_e F3_MAP [8] = '{AluAdd, AluSll, AluSlt, AluSltu,
                                       AluXor, AluSrl, AluOr, AluAnd};

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .rd_in     (rd_in),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .rd_out    (rd_out),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected packet for the inputs currently driven, from the ISA rules.
    function automatic issue_pkt_t ref_pkt();
        issue_pkt_t  p;
        logic [31:0] s1 = rs1_data;
        logic [31:0] s2 = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid && fwd_rd != 0 && fwd_rd == rs1_addr) s1 = fwd_data;
        if (fwd_valid && fwd_rd != 0 && fwd_rd == rs2_addr) s2 = fwd_data;
`endif
        p = '0;
        p.rd = rd_in;
        if (opcode == OPC_OP) begin
            p.a = s1;
            p.b = s2;
            p.alu_ctrl = F3_MAP[funct3];
            if (funct7_5 && funct3 == 3'd0) p.alu_ctrl = AluSub;
            if (funct7_5 && funct3 == 3'd5) p.alu_ctrl = AluSra;
        end else if (opcode == OPC_OP_IMM) begin
            p.a = s1;
            p.b = imm;
            p.alu_ctrl = F3_MAP[funct3];
            if (funct7_5 && funct3 == 3'd5) p.alu_ctrl = AluSra;
        end else if (opcode == OPC_LUI) begin
            p.a = 32'd0;
            p.b = imm;
            p.alu_ctrl = AluPassB;
        end else begin
            p.a = s1;
            p.b = s2;
            p.alu_ctrl = AluAdd;
            p.illegal = 1'b1;
        end
        return p;
    endfunction

    // One cycle: compare at negedge against the model, then advance the model
    // at the rising edge; returns at posedge + 1.
    task automatic step();
        issue_pkt_t nxt;
        issue_pkt_t head;
        bit acc, drn;
        @(negedge clk);
        check("out_valid", out_valid, exp_q.size() != 0);
        check("in_ready", in_ready, exp_q.size() < 2);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("pkt", {a, b, alu_ctrl, rd_out, illegal}, head);
        end
        acc = in_valid && (exp_q.size() < 2) && !flush;
        drn = out_ready && (exp_q.size() != 0);
        nxt = ref_pkt();
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(nxt);
        end
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] im, input logic [4:0] rd);
        in_valid = 1'b1;
        opcode   = opc;
        funct3   = f3;
        funct7_5 = f7;
        rs1_data = d1;
        rs2_data = d2;
        imm      = im;
        rd_in    = rd;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2;
        rs1_data = '0; rs2_data = '0; imm = '0; rd_in = '0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_pkt", {a, b, alu_ctrl, rd_out, illegal}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("rst_in_ready", in_ready, 1);

        // OP ADD
        drive(OPC_OP, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 5'd10);
        step();
        check("add_valid", out_valid, 1);
        check("add_ab", {a, b}, {32'd3, 32'd4});
        check("add_ctrl", alu_ctrl, 4'b0000);

        // OP SUB
        drive(OPC_OP, 3'b000, 1'b1, 32'd7, 32'd4, 32'd0, 5'd11);
        step();
        check("sub_ctrl", alu_ctrl, 4'b0001);
        check("sub_b", b, 32'd4);

        // ADDI ignores bit 30
        drive(OPC_OP_IMM, 3'b000, 1'b1, 32'd7, 32'd4, 32'hFFFF_FFFF, 5'd12);
        step();
        check("addi_ctrl", alu_ctrl, 4'b0000);
        check("addi_b", b, 32'hFFFF_FFFF);

        // Illegal opcode
        drive(7'b1111111, 3'b011, 1'b1, 32'd5, 32'd6, 32'd9, 5'd13);
        step();
        check("ill_flag", illegal, 1);
        check("ill_ctrl_ab", {alu_ctrl, a, b}, {4'b0000, 32'd5, 32'd6});

        // LUI
        drive(OPC_LUI, 3'b000, 1'b0, 32'd77, 32'd6, 32'h1234_5000, 5'd14);
        step();
        check("lui_ab", {a, b}, {32'd0, 32'h1234_5000});
        check("lui_ctrl", alu_ctrl, 4'b1010);
        check("lui_illegal", illegal, 0);
        in_valid = 1'b0;
        step();

        // Stall and skid
        out_ready = 1'b0;
        drive(OPC_OP, 3'b100, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1);
        step();
        drive(OPC_OP, 3'b110, 1'b0, 32'd2, 32'd2, 32'd0, 5'd2);
        step();
        in_valid = 1'b0;
        check("stall_in_ready", in_ready, 0);
        step();
        check("stall_rd1", rd_out, 5'd1);
        out_ready = 1'b1;
        step();
        check("drain_rd2", rd_out, 5'd2);
        check("drain_in_ready", in_ready, 1);
        step();
        check("drain_empty", out_valid, 0);

        // Flush with both entries full; the flush-cycle input must vanish
        out_ready = 1'b0;
        drive(OPC_OP, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0, 5'd3);
        step();
        drive(OPC_OP, 3'b000, 1'b0, 32'd4, 32'd4, 32'd0, 5'd4);
        step();
        drive(OPC_OP, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 5'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) step();

        // Flush with room: input presented while flushing is discarded
        drive(OPC_OP, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 5'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_drop", out_valid, 0);

        // Asynchronous reset while stalled with both entries full
        out_ready = 1'b0;
        drive(OPC_OP, 3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 5'd5);
        step();
        drive(OPC_OP, 3'b010, 1'b0, 32'd6, 32'd6, 32'd0, 5'd6);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_rd", rd_out, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b1;

`ifdef ALU_ISSUE_FWD_EN
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'd99;
        drive(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd7);
        step();
        check("fwd_a", a, 32'd99);
        fwd_rd = 5'd6;
        step();
        check("fwd_b", b, 32'd99);
        rs1_addr = 5'd0; fwd_rd = 5'd0;
        step();
        check("fwd_x0", a, 32'd1);
        fwd_valid = 1'b0;
        in_valid = 1'b0;
        step();
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            opcode    = (sel == 0) ? OPC_OP : (sel == 1) ? OPC_OP_IMM :
                        (sel == 2) ? OPC_LUI : 7'($urandom);
            funct3    = 3'($urandom);
            funct7_5  = 1'($urandom);
            rs1_addr  = 5'($urandom_range(0, 3));
            rs2_addr  = 5'($urandom_range(0, 3));
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            imm       = $urandom;
            rd_in     = 5'($urandom);
            fwd_valid = 1'($urandom);
            fwd_rd    = 5'($urandom_range(0, 3));
            fwd_data  = $urandom;
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
